// File: rtl/pixel_write_receiver_if.sv
// rtl/pixel_write_receiver_if.sv - painter strobe and video memory write bundle
// Purpose: groups the painter pixel strobe and the memory write handshake.
// Ports (signals):
//   paint_x_co, paint_y_co, color, print_enable : painter -> receiver
//   mem_ready                                   : memory -> receiver
//   mem_addr, mem_data, mem_wren                : receiver -> memory
// Modports: slave = receiver side, master = painter/memory side.
interface pixel_write_receiver_if #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 7,
  parameter int COLOR_SIZE = 3,
  parameter int ADDR_BITS  = 15
);
  logic [X_BITS-1:0]     paint_x_co;
  logic [Y_BITS-1:0]     paint_y_co;
  logic [COLOR_SIZE-1:0] color;
  logic                  print_enable;
  logic                  mem_ready;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [COLOR_SIZE-1:0] mem_data;
  logic                  mem_wren;

  modport slave (
    input  paint_x_co, paint_y_co, color, print_enable, mem_ready,
    output mem_addr, mem_data, mem_wren
  );

  modport master (
    output paint_x_co, paint_y_co, color, print_enable, mem_ready,
    input  mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/pixel_write_receiver.sv
// rtl/pixel_write_receiver.sv - pixel strobe capture, FIFO and framebuffer write engine
// Purpose: captures one pixel per print_enable rising edge, range-checks it, converts it
// to a linear address, queues it and drains it into the memory write port; also fills
// the whole screen with CLEAR_COLOR on request.
// Ports:
//   Clck, Reset  : clock, asynchronous active-high reset
//   bus          : painter strobe inputs and memory write port (slave modport)
//   clear_start  : one-cycle clear request
//   fifo_count   : current FIFO occupancy
//   overflow     : sticky, pixel dropped on full FIFO
//   range_err    : sticky, pixel dropped for out-of-screen coordinates
//   clear_done   : one-cycle pulse after the last clear write is accepted
module pixel_write_receiver #(
  parameter int                    SCR_WIDTH   = 160,
  parameter int                    SCR_HEIGHT  = 120,
  parameter int                    X_BITS      = 8,
  parameter int                    Y_BITS      = 7,
  parameter int                    COLOR_SIZE  = 3,
  parameter int                    ADDR_BITS   = 15,
  parameter int                    FIFO_DEPTH  = 4,
  parameter logic [COLOR_SIZE-1:0] CLEAR_COLOR = '0
) (
  input  logic                         Clck,
  input  logic                         Reset,
  pixel_write_receiver_if.slave        bus,
  input  logic                         clear_start,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         range_err,
  output logic                         clear_done
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_BITS + COLOR_SIZE;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SCR_WIDTH * SCR_HEIGHT - 1);
  localparam logic [X_BITS:0]      X_LIM     = (X_BITS + 1)'(SCR_WIDTH);
  localparam logic [Y_BITS:0]      Y_LIM     = (Y_BITS + 1)'(SCR_HEIGHT);
  localparam logic [PTR_W:0]       FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  state_t               state, state_n;
  logic                 pe_q;
  logic                 capture, in_range, push, pop;
  logic                 fifo_empty, fifo_full;
  logic [ADDR_BITS-1:0] pix_addr;
  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0]   head;
  logic [ADDR_BITS-1:0] clr_addr;
  logic                 clear_pending;
  logic                 load_head, enter_clear, clr_inc, wren_n, done_n;

  // Capture on the rising edge of the strobe only, however long it is held.
  assign capture  = bus.print_enable & ~pe_q;
  // One extra bit on the compare so a limit equal to 2^X_BITS still works.
  assign in_range = ({1'b0, bus.paint_x_co} < X_LIM) && ({1'b0, bus.paint_y_co} < Y_LIM);
  assign pix_addr = ADDR_BITS'(bus.paint_y_co) * ADDR_BITS'(SCR_WIDTH)
                  + ADDR_BITS'(bus.paint_x_co);

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == FULL_CNT);
  // Fullness uses the occupancy before this cycle's pop, so a full FIFO drops.
  assign push       = capture & in_range & ~fifo_full;
  assign head       = fifo_mem[rd_ptr];

  always_ff @(posedge Clck) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {pix_addr, bus.color};
    end
  end

  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    load_head   = 1'b0;
    enter_clear = 1'b0;
    clr_inc     = 1'b0;
    wren_n      = bus.mem_wren;
    done_n      = 1'b0;
    case (state)
      S_IDLE: begin
        // Queued pixels drain before a pending clear starts.
        if (!fifo_empty) begin
          pop       = 1'b1;
          load_head = 1'b1;
          wren_n    = 1'b1;
          state_n   = S_WRITE;
        end else if (clear_pending) begin
          enter_clear = 1'b1;
          wren_n      = 1'b1;
          state_n     = S_CLEAR;
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            load_head = 1'b1;
          end else begin
            wren_n  = 1'b0;
            state_n = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        if (bus.mem_ready) begin
          if (clr_addr == LAST_ADDR) begin
            wren_n  = 1'b0;
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else begin
            clr_inc = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clck or posedge Reset) begin
    if (Reset) begin
      pe_q          <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_data  <= '0;
      bus.mem_wren  <= 1'b0;
      clr_addr      <= '0;
      clear_pending <= 1'b0;
      clear_done    <= 1'b0;
      overflow      <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      pe_q         <= bus.print_enable;
      bus.mem_wren <= wren_n;
      clear_done   <= done_n;
      if (load_head) begin
        {bus.mem_addr, bus.mem_data} <= head;
      end else if (enter_clear) begin
        clr_addr     <= '0;
        bus.mem_addr <= '0;
        bus.mem_data <= CLEAR_COLOR;
      end else if (clr_inc) begin
        clr_addr     <= clr_addr + 1'b1;
        bus.mem_addr <= clr_addr + 1'b1;
      end
      // A request arriving in the same cycle as entry to CLEAR re-arms for another pass.
      if (clear_start)      clear_pending <= 1'b1;
      else if (enter_clear) clear_pending <= 1'b0;
      if (capture && !in_range)             range_err <= 1'b1;
      if (capture && in_range && fifo_full) overflow  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pixel_write_receiver.sv
// tb/tb_pixel_write_receiver.sv - self-checking bench for pixel_write_receiver
module tb_pixel_write_receiver;
  localparam int W      = 160;
  localparam int H      = 120;
  localparam int PIXELS = W * H;
  localparam int HOLD   = 5;  // FIFO entries plus the write held at the output

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear_start;
  logic [2:0] fifo_count;
  logic       overflow, range_err, clear_done;

  pixel_write_receiver_if intf ();

  pixel_write_receiver dut (
    .Clck        (clk),
    .Reset       (rst),
    .bus         (intf.slave),
    .clear_start (clear_start),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .range_err   (range_err),
    .clear_done  (clear_done)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  wr_t mon_e;
  bit  model_ovf, model_rerr, clear_mode;
  int  tests, fails;
  int  writes_seen, wren_cycles, clear_done_cnt, clr_idx;
  int  ready_mode;  // 0: never ready, 1: always ready, 2: random

  // One clock: observe at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (clear_done) clear_done_cnt++;
      if (intf.mem_wren) wren_cycles++;
      if (intf.mem_wren && intf.mem_ready) begin
        writes_seen++;
        tests++;
        if (clear_mode && clr_idx < PIXELS) begin
          if (intf.mem_addr !== clr_idx[14:0] || intf.mem_data !== 3'b000) begin
            fails++;
            $display("FAIL clear_write: got addr %0d data %0d, expected addr %0d data 0",
                     intf.mem_addr, intf.mem_data, clr_idx);
          end
          clr_idx++;
        end else if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d, expected no write",
                   intf.mem_addr, intf.mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (intf.mem_addr !== mon_e.addr || intf.mem_data !== mon_e.data) begin
            fails++;
            $display("FAIL pixel_write: got addr %0d data %0d, expected addr %0d data %0d",
                     intf.mem_addr, intf.mem_data, mon_e.addr, mon_e.data);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       intf.mem_ready = 1'b0;
      1:       intf.mem_ready = 1'b1;
      default: intf.mem_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Reference model: what the painter's pixel should become, decided from screen rules.
  task automatic model_pixel(input int x, input int y, input int c);
    wr_t e;
    if (x >= W || y >= H) begin
      model_rerr = 1'b1;
    end else if (exp_q.size() >= HOLD) begin
      model_ovf = 1'b1;
    end else begin
      e.addr = 15'(y * W + x);
      e.data = 3'(c);
      exp_q.push_back(e);
    end
  endtask

  task automatic strobe(input int x, input int y, input int c, input int hold);
    intf.paint_x_co   = 8'(x);
    intf.paint_y_co   = 7'(y);
    intf.color        = 3'(c);
    intf.print_enable = 1'b1;
    model_pixel(x, y, c);
    repeat (hold) tick();
    intf.print_enable = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || intf.mem_wren) && n < max_cycles) begin
      tick();
      n++;
    end
    tests++;
    if (n >= max_cycles) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending after %0d cycles, expected 0",
               exp_q.size(), n);
    end
  endtask

  task automatic apply_reset();
    rst               = 1'b1;
    clear_start       = 1'b0;
    intf.print_enable = 1'b0;
    intf.paint_x_co   = '0;
    intf.paint_y_co   = '0;
    intf.color        = '0;
    exp_q.delete();
    model_ovf  = 1'b0;
    model_rerr = 1'b0;
    clear_mode = 1'b0;
    clr_idx    = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({intf.mem_wren, fifo_count, overflow, range_err, clear_done} !== 7'b0) begin
      fails++;
      $display("FAIL reset_state: got wren %0b count %0d ovf %0b rerr %0b done %0b, expected all 0",
               intf.mem_wren, fifo_count, overflow, range_err, clear_done);
    end
  endtask

  task automatic test_single();
    int w0, n0;
    ready_mode = 1;
    tick();
    w0 = wren_cycles;
    n0 = writes_seen;
    intf.paint_x_co   = 8'd5;
    intf.paint_y_co   = 7'd2;
    intf.color        = 3'b100;
    intf.print_enable = 1'b1;
    model_pixel(5, 2, 3'b100);
    tick();  // capture edge
    tests++;
    if (intf.mem_wren !== 1'b0 || fifo_count !== 3'd1) begin
      fails++;
      $display("FAIL latency_capture: got wren %0b count %0d, expected wren 0 count 1",
               intf.mem_wren, fifo_count);
    end
    intf.print_enable = 1'b0;
    tick();
    tests++;
    if (intf.mem_wren !== 1'b1 || intf.mem_addr !== 15'd325) begin
      fails++;
      $display("FAIL latency_write: got wren %0b addr %0d, expected wren 1 addr 325",
               intf.mem_wren, intf.mem_addr);
    end
    wait_drain(20);
    repeat (2) tick();
    tests++;
    if (wren_cycles - w0 != 1 || writes_seen - n0 != 1) begin
      fails++;
      $display("FAIL single_wren_cycles: got %0d cycles %0d writes, expected 1 and 1",
               wren_cycles - w0, writes_seen - n0);
    end
  endtask

  task automatic test_hold();
    int n0 = writes_seen;
    strobe(0, 0, 3'b011, 3);
    wait_drain(20);
    repeat (3) tick();
    tests++;
    if (writes_seen - n0 != 1) begin
      fails++;
      $display("FAIL hold_one_write: got %0d writes, expected 1", writes_seen - n0);
    end
  endtask

  task automatic test_range();
    int w0 = wren_cycles;
    strobe(160, 0, 1, 1);
    strobe(3, 120, 2, 1);
    repeat (4) tick();
    tests++;
    if (wren_cycles != w0 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL range_no_write: got %0d wren cycles count %0d, expected 0 and 0",
               wren_cycles - w0, fifo_count);
    end
    tests++;
    if (range_err !== model_rerr || overflow !== model_ovf) begin
      fails++;
      $display("FAIL range_flags: got rerr %0b ovf %0b, expected rerr %0b ovf %0b",
               range_err, overflow, model_rerr, model_ovf);
    end
  endtask

  task automatic test_overflow();
    int n0;
    apply_reset();
    ready_mode = 0;
    tick();
    n0 = writes_seen;
    for (int i = 1; i <= 6; i++) strobe(i, 0, i % 8, 1);
    tests++;
    if (fifo_count !== 3'd4 || intf.mem_wren !== 1'b1 || intf.mem_addr !== exp_q[0].addr) begin
      fails++;
      $display("FAIL overflow_hold: got count %0d wren %0b addr %0d, expected 4 1 %0d",
               fifo_count, intf.mem_wren, intf.mem_addr, exp_q[0].addr);
    end
    tests++;
    if (overflow !== model_ovf || model_ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flag: got %0b, expected 1", overflow);
    end
    ready_mode = 1;
    wait_drain(40);
    tests++;
    if (writes_seen - n0 != 5 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL overflow_drain: got %0d writes count %0d, expected 5 and 0",
               writes_seen - n0, fifo_count);
    end
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      n = 0;
      while (exp_q.size() > 3 && n < 200) begin
        tick();
        n++;
      end
      strobe($urandom_range(0, 170), $urandom_range(0, 125), $urandom_range(0, 7),
             $urandom_range(1, 3));
    end
    ready_mode = 1;
    wait_drain(100);
    tests++;
    if (overflow !== model_ovf || range_err !== model_rerr || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL random_flags: got ovf %0b rerr %0b count %0d, expected ovf %0b rerr %0b count 0",
               overflow, range_err, fifo_count, model_ovf, model_rerr);
    end
  endtask

  task automatic test_clear();
    int d0;
    apply_reset();
    ready_mode = 1;
    d0 = clear_done_cnt;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    clear_mode  = 1'b1;
    repeat (10) tick();
    strobe(7, 3, 3'b101, 1);  // captured during the clear, written after it
    wait_drain(PIXELS + 200);
    repeat (3) tick();
    clear_mode = 1'b0;
    tests++;
    if (clr_idx != PIXELS) begin
      fails++;
      $display("FAIL clear_count: got %0d clear writes, expected %0d", clr_idx, PIXELS);
    end
    tests++;
    if (clear_done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL clear_done_pulse: got %0d pulses, expected 1", clear_done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    ready_mode = 0;
    tick();
    strobe(200, 0, 1, 1);
    strobe(1, 0, 2, 1);
    strobe(2, 0, 3, 1);
    tests++;
    if (intf.mem_wren !== 1'b1 || range_err !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_state: got wren %0b rerr %0b, expected 1 and 1",
               intf.mem_wren, range_err);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({intf.mem_wren, fifo_count, overflow, range_err, clear_done} !== 7'b0) begin
      fails++;
      $display("FAIL async_reset: got wren %0b count %0d ovf %0b rerr %0b done %0b, expected all 0",
               intf.mem_wren, fifo_count, overflow, range_err, clear_done);
    end
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    intf.mem_ready = 1'b0;
    ready_mode     = 1;
    tests          = 0;
    fails          = 0;
    writes_seen    = 0;
    wren_cycles    = 0;
    clear_done_cnt = 0;
    test_reset();
    test_single();
    test_hold();
    test_range();
    test_overflow();
    test_random();
    test_clear();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
